// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Front-end stage for a 4-bit combinational ALU. Commands (a, b, op) are
// buffered in a small FIFO. They are issued one at a time on registered
// ALU-driving outputs. The ALU result is captured into a registered output
// that is held under a valid/ready handshake. Opcodes 3'b110/3'b111 are not
// decoded by the ALU. They are issued as a zero command and reported with
// out_err = 1.
//
// Handshakes: a transfer happens on the rising clk edge where valid and ready
// are both high. A producer holds its payload stable while valid is high and
// ready is low. A consumer may raise or lower ready at any time.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    command handshake (in_a, in_b, in_op payload)
//   alu_a, alu_b, alu_c  registered operands/opcode driving the ALU
//   alu_o                combinational ALU result
//   out_valid/out_ready  result handshake (out_data, out_op, out_err payload)
//   busy                 FIFO non-empty or FSM not idle
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [2:0] in_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_c,
    input  logic [7:0] alu_o,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] out_op,
    output logic       out_err,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // FIFO entry layout: {a[3:0], b[3:0], op[2:0]}
    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [1:0]    r_state;
    logic [3:0]    r_alu_a;
    logic [3:0]    r_alu_b;
    logic [2:0]    r_alu_c;
    logic          r_illegal;
    logic [2:0]    r_pend_op;
    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic [2:0]    r_out_op;
    logic          r_out_err;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [10:0]   w_head;
    logic [2:0]    w_head_op;
    logic          w_head_ill;

    // Ready comes only from the registered count. A pop in the same cycle
    // does not free a slot early, so a full FIFO never accepts a command.
    // Ready is also held low while reset is asserted.
    assign w_in_ready = rst_n && (r_count != DEPTH_C);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = (r_count != '0) &&
                        ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_op  = w_head[2:0];
    assign w_head_ill = w_head_op[2] & w_head_op[1];

    // Storage needs no reset. The pointers and the count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b, in_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_c     <= '0;
            r_illegal   <= 1'b0;
            r_pend_op   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_op    <= '0;
            r_out_err   <= 1'b0;
        end else begin
            // The issue path is shared by IDLE and HOLD. w_pop only fires in
            // those states. An illegal opcode drives the ALU with a harmless
            // all-zero command. The real opcode is kept for reporting.
            if (w_pop) begin
                r_pend_op <= w_head_op;
                r_illegal <= w_head_ill;
                if (w_head_ill) begin
                    r_alu_a <= '0;
                    r_alu_b <= '0;
                    r_alu_c <= 3'b000;
                end else begin
                    r_alu_a <= w_head[10:7];
                    r_alu_b <= w_head[6:3];
                    r_alu_c <= w_head_op;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // The ALU inputs have been stable for a full cycle.
                    r_out_data  <= r_illegal ? 8'h00 : alu_o;
                    r_out_op    <= r_pend_op;
                    r_out_err   <= r_illegal;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_pop ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_c     = r_alu_c;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_op    = r_out_op;
    assign out_err   = r_out_err;
    assign busy      = (r_count != '0) || (r_state != S_IDLE);

endmodule
